mem_bus_arbiter: RTL and testbench

- Shares one Avalon-style memory bus between the CPU's instruction-fetch port and its data-access port.
- Sits between the CPU core (fetch stage and load/store path) and the single external memory interface.
- Serialises requests using a small FSM, with data-port priority and a starvation guard for fetch.
- Honours bus waitrequest and returns completion strobes to each requester.

---
 rtl/mem_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one Avalon-style memory bus.
// Optional waitrequest watchdog is enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int unsigned MAX_DATA_BURST = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ready,
  output logic [31:0] instr_rdata,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_byteenable,
  output logic        data_ready,
  output logic [31:0] data_rdata,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_writedata,
  output logic [3:0]  bus_byteenable,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, IFETCH, DACCESS} state_e;

  localparam int unsigned          BURST_W   = $clog2(MAX_DATA_BURST + 1);
  localparam logic [BURST_W-1:0]   BURST_MAX = BURST_W'(MAX_DATA_BURST);

  state_e               state_q, state_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [31:0]          addr_d, wdata_d, rsp_data;
  logic [3:0]           be_d;
  logic                 read_d, write_d;
  logic                 data_req, xfer_done, timed_out, finish;

  assign data_req  = data_read | data_write;
  // Readies are suppressed during reset so an aborted transfer never completes.
  assign xfer_done = (state_q != IDLE) && !bus_waitrequest && !reset;
  assign finish    = xfer_done | timed_out;
  assign rsp_data  = timed_out ? 32'hDEADBEEF : bus_readdata;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned        WAIT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              error_q;

  assign timed_out = (state_q != IDLE) && bus_waitrequest && !reset &&
                     (wait_cnt_q == WAIT_MAX);

  // Counter is held at zero while idle, so every grant starts a fresh count.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == IDLE)
      wait_cnt_d = '0;
    else if (bus_waitrequest && !timed_out)
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (timed_out) error_q <= 1'b1;
    end
  end

  assign bus_error = error_q;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

  assign timed_out = 1'b0;
  assign bus_error = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    addr_d      = bus_address;
    read_d      = bus_read;
    write_d     = bus_write;
    wdata_d     = bus_writedata;
    be_d        = bus_byteenable;
    instr_ready = 1'b0;
    instr_rdata = 32'h0;
    data_ready  = 1'b0;
    data_rdata  = 32'h0;

    case (state_q)
      IDLE: begin
        // Data wins unless it has already used its burst allowance over a waiting fetch.
        if (data_req && (!instr_req || burst_cnt_q < BURST_MAX)) begin
          state_d = DACCESS;
          addr_d  = data_addr;
          read_d  = data_read & ~data_write;
          write_d = data_write;
          wdata_d = data_wdata;
          be_d    = data_byteenable;
        end else if (instr_req) begin
          state_d = IFETCH;
          addr_d  = instr_addr;
          read_d  = 1'b1;
          write_d = 1'b0;
          be_d    = 4'b1111;
        end
      end

      IFETCH: begin
        if (finish) begin
          instr_ready = 1'b1;
          instr_rdata = rsp_data;
          state_d     = IDLE;
          read_d      = 1'b0;
          write_d     = 1'b0;
          burst_cnt_d = '0;
        end
      end

      DACCESS: begin
        if (finish) begin
          data_ready = 1'b1;
          data_rdata = rsp_data;
          state_d    = IDLE;
          read_d     = 1'b0;
          write_d    = 1'b0;
          if (!instr_req)
            burst_cnt_d = '0;
          else if (burst_cnt_q < BURST_MAX)
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers update with non-blocking assignments so all of them sample pre-edge values.
    if (reset) begin
      state_q        <= IDLE;
      burst_cnt_q    <= '0;
      bus_address    <= 32'h0;
      bus_read       <= 1'b0;
      bus_write      <= 1'b0;
      bus_writedata  <= 32'h0;
      bus_byteenable <= 4'b1111;
    end else begin
      state_q        <= state_d;
      burst_cnt_q    <= burst_cnt_d;
      bus_address    <= addr_d;
      bus_read       <= read_d;
      bus_write      <= write_d;
      bus_writedata  <= wdata_d;
      bus_byteenable <= be_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table plus hand sequences,
// with a scoreboard of expected completions popped whenever a ready strobe appears.
module tb_mem_bus_arbiter;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_ready;
  logic [31:0] instr_rdata;
  logic        data_read, data_write;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_byteenable;
  logic        data_ready;
  logic [31:0] data_rdata;
  logic [31:0] bus_address;
  logic        bus_read, bus_write;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteenable;
  logic        bus_waitrequest;
  logic [31:0] bus_readdata;
  logic        bus_error;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_DATA_BURST(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_ready(instr_ready), .instr_rdata(instr_rdata),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_byteenable(data_byteenable),
    .data_ready(data_ready), .data_rdata(data_rdata),
    .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
    .bus_writedata(bus_writedata), .bus_byteenable(bus_byteenable),
    .bus_waitrequest(bus_waitrequest), .bus_readdata(bus_readdata),
    .bus_error(bus_error)
  );

  typedef struct {
    logic        is_data;
    logic        chk_rdata;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        is_data;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          waits;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_data, input logic chk, input logic [31:0] rd);
    exp_t e;
    e.is_data   = is_data;
    e.chk_rdata = chk;
    e.rdata     = rd;
    sb_q.push_back(e);
  endtask

  // Sample at the falling edge; any ready strobe must match the oldest expectation.
  task automatic settle();
    exp_t e;
    @(negedge clk);
    if (instr_ready || data_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ready: got instr_ready=%0b data_ready=%0b, expected none",
                 instr_ready, data_ready);
      end else begin
        e = sb_q.pop_front();
        check("ready_port_data", 32'(data_ready), 32'(e.is_data));
        check("ready_port_instr", 32'(instr_ready), 32'(!e.is_data));
        if (e.chk_rdata)
          check("rdata", e.is_data ? data_rdata : instr_rdata, e.rdata);
      end
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs();
    instr_req  = 1'b0;
    data_read  = 1'b0;
    data_write = 1'b0;
  endtask

  task automatic check_bus(input vec_t v);
    check("bus_read",  32'(bus_read),  32'(v.is_data ? (v.rd & ~v.wr) : 1'b1));
    check("bus_write", 32'(bus_write), 32'(v.is_data & v.wr));
    check("bus_address", bus_address, v.addr);
    check("bus_byteenable", 32'(bus_byteenable), 32'(v.is_data ? v.be : 4'hF));
    if (v.is_data && v.wr) check("bus_writedata", bus_writedata, v.wdata);
  endtask

  task automatic run_vec(input vec_t v);
    instr_req       = !v.is_data;
    data_read       = v.is_data & v.rd;
    data_write      = v.is_data & v.wr;
    instr_addr      = v.addr;
    data_addr       = v.addr;
    data_wdata      = v.wdata;
    data_byteenable = v.be;
    bus_readdata    = v.rdata;
    bus_waitrequest = 1'b0;
    push_exp(v.is_data, !(v.is_data && v.wr), v.rdata);
    settle();
    check("idle_before_grant", 32'(bus_read | bus_write), 32'h0);
    next();
    for (int w = 0; w <= v.waits; w++) begin
      bus_waitrequest = (w < v.waits);
      settle();
      check_bus(v);
      check("ready_timing", 32'(v.is_data ? data_ready : instr_ready), 32'(w == v.waits));
      next();
      if (w == v.waits) drop_reqs();
    end
    bus_waitrequest = 1'b0;
    settle();
    check("strobes_clear", 32'(bus_read | bus_write), 32'h0);
    next();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drop_reqs();
    instr_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0;
    data_byteenable = 4'hF; bus_waitrequest = 1'b0; bus_readdata = 32'h55AA55AA;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'hBFC00000, 32'h0,        4'hF, 32'h24020005, 0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h00002000, 32'h0,        4'hF, 32'h12345678, 3};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h00001000, 32'hCAFEF00D, 4'h3, 32'h0,        0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h00003004, 32'hA5A5A5A5, 4'hC, 32'h0,        1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h00000004, 32'h0,        4'hF, 32'h8C220000, 2};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        4'h1, 32'h000000FF, 0};

    repeat (2) next();
    reset = 1'b0;
    settle();
    check("rst_bus_read", 32'(bus_read), 32'h0);
    check("rst_bus_write", 32'(bus_write), 32'h0);
    check("rst_bus_address", bus_address, 32'h0);
    check("rst_bus_writedata", bus_writedata, 32'h0);
    check("rst_bus_byteenable", 32'(bus_byteenable), 32'hF);
    check("rst_readies", 32'({instr_ready, data_ready}), 32'h0);
    check("rst_instr_rdata", instr_rdata, 32'h0);
    check("rst_data_rdata", data_rdata, 32'h0);
    check("rst_bus_error", 32'(bus_error), 32'h0);
    next();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Fetch and store arrive together: store first, fetch right after.
    instr_req = 1'b1; instr_addr = 32'hBFC00010;
    data_write = 1'b1; data_addr = 32'h00001000; data_wdata = 32'hCAFEF00D;
    data_byteenable = 4'b0011; bus_readdata = 32'h11112222;
    push_exp(1'b1, 1'b0, 32'h0);
    push_exp(1'b0, 1'b1, 32'h11112222);
    settle(); next();
    settle();
    check("prio_bus_write", 32'(bus_write), 32'h1);
    check("prio_bus_read", 32'(bus_read), 32'h0);
    check("prio_be", 32'(bus_byteenable), 32'h3);
    check("prio_addr", bus_address, 32'h00001000);
    next();
    data_write = 1'b0;
    settle(); next();
    settle();
    check("prio_fetch_read", 32'(bus_read), 32'h1);
    check("prio_fetch_addr", bus_address, 32'hBFC00010);
    check("prio_fetch_ready", 32'(instr_ready), 32'h1);
    next();
    drop_reqs();
    settle(); next();

    // Data floods while fetch waits: four data grants, one fetch, data again.
    instr_req = 1'b1; instr_addr = 32'h00400000;
    data_read = 1'b1; data_byteenable = 4'hF;
    for (int k = 0; k < 6; k++) begin
      data_addr    = 32'h00004000 + 32'(4 * k);
      bus_readdata = 32'hD0000000 + 32'(k);
      push_exp(k != 4, 1'b1, bus_readdata);
      settle();
      check("burst_idle", 32'(bus_read | bus_write), 32'h0);
      next();
      settle();
      check("burst_grant_addr", bus_address, (k == 4) ? instr_addr : data_addr);
      check("burst_fetch_grant", 32'(instr_ready), 32'(k == 4));
      next();
    end
    drop_reqs();
    settle(); next();

    // Reset lands on a stalled write.
    data_write = 1'b1; data_addr = 32'h00005000; data_wdata = 32'h0BADF00D;
    data_byteenable = 4'hF; bus_waitrequest = 1'b1;
    settle(); next();
    settle();
    check("rstmid_write_active", 32'(bus_write), 32'h1);
    reset = 1'b1;
    settle();
    check("rstmid_no_ready", 32'(data_ready), 32'h0);
    next();
    reset = 1'b0;
    drop_reqs();
    settle();
    check("rstmid_write_dropped", 32'(bus_write), 32'h0);
    check("rstmid_addr_cleared", bus_address, 32'h0);
    bus_waitrequest = 1'b0;
    next();
    settle();
    check("rstmid_stays_idle", 32'(bus_read | bus_write | data_ready), 32'h0);
    next();

`ifdef ARB_TIMEOUT_EN
    instr_req = 1'b1; instr_addr = 32'hBFC00020;
    bus_waitrequest = 1'b1; bus_readdata = 32'h12345678;
    push_exp(1'b0, 1'b1, 32'hDEADBEEF);
    settle(); next();
    for (int j = 1; j <= int'(TMO); j++) begin
      settle();
      check("tmo_waiting_read", 32'(bus_read), 32'h1);
      check("tmo_no_early_ready", 32'(instr_ready), 32'h0);
      next();
    end
    settle();
    check("tmo_ready", 32'(instr_ready), 32'h1);
    next();
    instr_req = 1'b0;
    settle();
    check("tmo_read_dropped", 32'(bus_read), 32'h0);
    check("tmo_error_set", 32'(bus_error), 32'h1);
    bus_waitrequest = 1'b0;
    repeat (3) next();
    settle();
    check("tmo_error_sticky", 32'(bus_error), 32'h1);
    next();
`else
    check("no_timeout_error", 32'(bus_error), 32'h0);
`endif

    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
